// File: rtl/fht_unload_if.sv
`default_nettype none
// ============================================================================
// fht_unload_if : bank-read, stream-out and control bundle of the FHT unloader
// Rev 1.0
// ============================================================================
interface fht_unload_if #(
    parameter int D_BIT = 22,
    parameter int A_BIT = 8
);
    logic             iRDY;
    logic [A_BIT-1:0] oADDR_RD_0;
    logic [A_BIT-1:0] oADDR_RD_1;
    logic [A_BIT-1:0] oADDR_RD_2;
    logic [A_BIT-1:0] oADDR_RD_3;
    logic [D_BIT-1:0] iDATA_0;
    logic [D_BIT-1:0] iDATA_1;
    logic [D_BIT-1:0] iDATA_2;
    logic [D_BIT-1:0] iDATA_3;
    logic [D_BIT-1:0] oDATA;
    logic [A_BIT+1:0] oIDX;
    logic             oVALID;
    logic             iREADY;
    logic             oLAST;
    logic             oBUSY;
    logic             oDONE;

    // master is the unloader itself, slave is the FHT core / RAM / sink side
    modport master (
        input  iRDY, iDATA_0, iDATA_1, iDATA_2, iDATA_3, iREADY,
        output oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3,
        output oDATA, oIDX, oVALID, oLAST, oBUSY, oDONE
    );

    modport slave (
        output iRDY, iDATA_0, iDATA_1, iDATA_2, iDATA_3, iREADY,
        input  oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3,
        input  oDATA, oIDX, oVALID, oLAST, oBUSY, oDONE
    );
endinterface
`default_nettype wire

// File: rtl/fht_unload.sv
`default_nettype none
// ============================================================================
// fht_unload : streams one FHT frame out of four bit-reversed RAM banks
// Rev 1.0
// ============================================================================
module fht_unload #(
    parameter int D_BIT  = 22,
    parameter int A_BIT  = 8,
    parameter int RD_LAT = 2
) (
    input  logic         iCLK,
    input  logic         iRESET,
    fht_unload_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SEND  = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    localparam logic [A_BIT-1:0] J_LAST = {A_BIT{1'b1}};
    localparam logic [1:0]       LAT    = 2'(RD_LAT);

    function automatic logic [A_BIT-1:0] bit_rev(input logic [A_BIT-1:0] v);
        logic [A_BIT-1:0] r;
        r = '0;
        for (int i = 0; i < A_BIT; i++) begin
            r[i] = v[A_BIT-1-i];
        end
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [A_BIT-1:0] j_q, j_d;
    logic [1:0]       b_q, b_d;
    logic [1:0]       wcnt_q, wcnt_d;
    logic [A_BIT-1:0] addr_q, addr_d;
    logic [D_BIT-1:0] line_q [4];
    logic [D_BIT-1:0] line_d [4];
    logic             rdy_q, rdy_d;

    logic             start;
    logic [A_BIT-1:0] j_inc;
    logic [1:0]       b_inc;

    assign start = bus.iRDY & ~rdy_q;
    assign j_inc = j_q + A_BIT'(1);
    assign b_inc = b_q + 2'd1;

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q <= ST_IDLE;
            j_q     <= '0;
            b_q     <= '0;
            wcnt_q  <= '0;
            addr_q  <= '0;
            line_q  <= '{default: '0};
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            b_q     <= b_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        b_d     = b_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        line_d  = line_q;
        rdy_d   = bus.iRDY;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    j_d     = '0;
                    b_d     = '0;
                    addr_d  = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                wcnt_d  = 2'd1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // the address register is untouched here, so the banks see a stable address
                if (wcnt_q == LAT) begin
                    line_d[0] = bus.iDATA_0;
                    line_d[1] = bus.iDATA_1;
                    line_d[2] = bus.iDATA_2;
                    line_d[3] = bus.iDATA_3;
                    b_d       = 2'd0;
                    state_d   = ST_SEND;
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            ST_SEND: begin
                if (bus.iREADY) begin
                    if (b_q != 2'd3) begin
                        b_d = b_inc;
                    end else if (j_q != J_LAST) begin
                        j_d     = j_inc;
                        addr_d  = bit_rev(j_inc);
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode registered state only, so iREADY never reaches them combinationally.
    assign bus.oADDR_RD_0 = addr_q;
    assign bus.oADDR_RD_1 = addr_q;
    assign bus.oADDR_RD_2 = addr_q;
    assign bus.oADDR_RD_3 = addr_q;
    assign bus.oDATA      = line_q[b_q];
    assign bus.oIDX       = {j_q, b_q};
    assign bus.oVALID     = (state_q == ST_SEND);
    assign bus.oLAST      = (state_q == ST_SEND) && (j_q == J_LAST) && (b_q == 2'd3);
    assign bus.oBUSY      = (state_q == ST_FETCH) || (state_q == ST_WAIT) || (state_q == ST_SEND);
    assign bus.oDONE      = (state_q == ST_FIN);

endmodule
`default_nettype wire
